// File: rtl/serial_adc_reader_if.sv
// Sample stream between serial_adc_reader and the downstream DSP chain:
// one-entry valid/ready register, data qualified by m_tvalid.
`timescale 1ns/1ps
interface serial_adc_reader_if #(
  parameter int DW = 16
) ();
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;

  modport master (
    output m_tdata,
    output m_tvalid,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    output m_tready
  );
endinterface

// File: rtl/serial_adc_reader.sv
// SPI-style read master for a single-channel serial ADC: free-running
// convert/read frames, MSB-first capture, one-entry valid/ready output.
`timescale 1ns/1ps
module serial_adc_reader #(
  parameter int DW          = 16,
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 32
) (
  input  logic                aclk,
  input  logic                areset_n,
  input  logic                en,
  output logic                sclk,
  output logic                cs_n,
  input  logic                sdo,
  serial_adc_reader_if.master axis,
  output logic                overrun
);

  localparam int CNT_MAX = (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(DW);

  localparam logic [CW-1:0] CONV_LOAD = CW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DW - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONV  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_bit;
  logic [DW-1:0] r_shift;
  logic          r_cs_n;
  logic          r_sclk;
  logic [DW-1:0] r_tdata;
  logic          r_tvalid;
  logic          r_overrun;

  logic          w_done;
  logic          w_take;

  assign w_done = (r_state == ST_DONE);
  assign w_take = r_tvalid && axis.m_tready;

  // Frame sequencer; cs_n and sclk change on the same edge as the state so
  // that they line up exactly with the CONV/SHIFT/DONE windows.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state <= ST_CONV;
            r_cnt   <= CONV_LOAD;
          end
        end
        ST_CONV: begin
          if (r_cnt == '0) begin
            r_state <= ST_SHIFT;
            r_cs_n  <= 1'b0;
            r_sclk  <= 1'b0;
            r_cnt   <= HALF_LOAD;
            r_bit   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_SHIFT: begin
          if (r_cnt == '0) begin
            r_cnt <= HALF_LOAD;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // sdo is sampled on the edge that drops sclk, before the ADC
              // moves on to its next bit.
              r_sclk  <= 1'b0;
              r_shift <= {r_shift[DW-2:0], sdo};
              if (r_bit == LAST_BIT) begin
                r_state <= ST_DONE;
                r_cs_n  <= 1'b1;
              end else begin
                r_bit <= r_bit + BW'(1);
              end
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DONE: begin
          if (en) begin
            r_state <= ST_CONV;
            r_cnt   <= CONV_LOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output register: a handshake on the DONE edge frees the slot for the
  // new sample in the same cycle, so back-to-back delivery has no bubble.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_done) begin
        if (!r_tvalid || axis.m_tready) begin
          r_tdata  <= r_shift;
          r_tvalid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_take) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign cs_n          = r_cs_n;
  assign sclk          = r_sclk;
  assign overrun       = r_overrun;
  assign axis.m_tdata  = r_tdata;
  assign axis.m_tvalid = r_tvalid;

endmodule
